// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for the code-ROM arbiter.
//   owner_e          - response owner encoding (NONE / I / D)
//   ROM_ADDR_W       - default ROM word-address width
//   ROM_DATA_W       - default ROM data width
//   STARVE_LIMIT_MAX - largest starvation limit the 4-bit streak counter supports
package rom_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int ROM_ADDR_W       = 10;
  localparam int ROM_DATA_W       = 32;
  localparam int STARVE_LIMIT_MAX = 15;

endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: bundles the fetch (i_*), load (d_*) and ROM (rom_*) signals.
//   modport slave  - arbiter side: takes requests and rom_q, drives acks,
//                    responses and rom_addr.
//   modport master - requester/ROM side: the mirror image.
interface rom_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);

  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ack;
  logic              i_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  logic              d_req;
  logic [31:0]       d_addr;
  logic              d_ack;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, rom_q,
    output i_ack, i_valid, i_rdata, i_err,
    output d_ack, d_valid, d_rdata, d_err,
    output rom_addr
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, rom_q,
    input  i_ack, i_valid, i_rdata, i_err,
    input  d_ack, d_valid, d_rdata, d_err,
    input  rom_addr
  );

endinterface

// File: rtl/rom_arb_starve_cnt.sv
// rom_arb_starve_cnt: 4-bit saturating streak counter.
//   m_clock  - clock
//   rst_n    - async active-low reset, clears the count
//   inc      - count up (stops at LIMIT)
//   clr      - clear to zero, dominates inc
//   at_limit - count equals LIMIT
module rom_arb_starve_cnt #(
  parameter logic [3:0] LIMIT = 4'd4
) (
  input  logic m_clock,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [3:0] count_q;

  always_ff @(posedge m_clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else if (clr) begin
      count_q <= 4'd0;
    end else if (inc && (count_q != LIMIT)) begin
      count_q <= count_q + 4'd1;
    end
  end

  assign at_limit = (count_q == LIMIT);

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous code ROM (1-cycle read latency) between
// instruction fetch (I) and data load (D). D wins conflicts until it has won
// STARVE_LIMIT times in a row against a waiting I, then I is forced through.
//   m_clock - system clock
//   rst_n   - async active-low reset
//   bus     - rom_arbiter_if.slave: i_*/d_* request/ack/response, rom_addr/rom_q
// Optional build macro ROM_ARB_RANGE_CHK_EN: flags addresses beyond the ROM
// (x_err with zero data) instead of aliasing them, and leaves rom_addr alone.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W       = ROM_ADDR_W,
  parameter int DATA_W       = ROM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          m_clock,
  input  logic          rst_n,
  rom_arbiter_if.slave  bus
);

  owner_e            owner_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              at_limit;
  logic              gnt_i;
  logic              gnt_d;
  logic              gnt_any;
  logic [31:0]       gnt_addr;
  logic              oor;
  logic              upd;
  logic              err_q;
  logic              unused_addr_bits;

  // D wins unless I is waiting and D has already used up its streak.
  assign gnt_d   = bus.d_req & ~(bus.i_req & at_limit);
  assign gnt_i   = bus.i_req & ~gnt_d;
  assign gnt_any = gnt_i | gnt_d;

  rom_arb_starve_cnt #(
    .LIMIT (4'(STARVE_LIMIT))
  ) u_starve_cnt (
    .m_clock  (m_clock),
    .rst_n    (rst_n),
    .inc      (gnt_d & bus.i_req),
    .clr      (gnt_i | ~bus.i_req),
    .at_limit (at_limit)
  );

  assign bus.i_ack = gnt_i;
  assign bus.d_ack = gnt_d;

  assign gnt_addr = gnt_d ? bus.d_addr : bus.i_addr;

`ifdef ROM_ARB_RANGE_CHK_EN
  assign oor = |gnt_addr[31:ADDR_W+2];
  assign unused_addr_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0]};
`else
  // Upper bits alias onto the ROM.
  assign oor = 1'b0;
  assign unused_addr_bits = ^{bus.i_addr[1:0], bus.d_addr[1:0],
                              bus.i_addr[31:ADDR_W+2], bus.d_addr[31:ADDR_W+2]};
`endif

  assign upd = gnt_any & ~oor;

  // Holding the last address on idle cycles keeps the ROM address bus quiet.
  assign bus.rom_addr = upd ? gnt_addr[ADDR_W+1:2] : rom_addr_q;

  always_ff @(posedge m_clock or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      rom_addr_q <= '0;
    end else begin
      if (gnt_d) begin
        owner_q <= OWN_D;
      end else if (gnt_i) begin
        owner_q <= OWN_I;
      end else begin
        owner_q <= OWN_NONE;
      end
      if (upd) begin
        rom_addr_q <= gnt_addr[ADDR_W+1:2];
      end
    end
  end

`ifdef ROM_ARB_RANGE_CHK_EN
  always_ff @(posedge m_clock or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= gnt_any & oor;
    end
  end
`else
  assign err_q = 1'b0;
`endif

  assign bus.i_valid = (owner_q == OWN_I);
  assign bus.d_valid = (owner_q == OWN_D);
  assign bus.i_err   = bus.i_valid & err_q;
  assign bus.d_err   = bus.d_valid & err_q;
  assign bus.i_rdata = (bus.i_valid & ~err_q) ? bus.rom_q : '0;
  assign bus.d_rdata = (bus.d_valid & ~err_q) ? bus.rom_q : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed bench for rom_arbiter with a behavioural 1-cycle ROM.
// Inputs change on the falling edge; outputs are sampled 1 ns later, before
// the next rising edge. Build with or without ROM_ARB_RANGE_CHK_EN.
module tb_rom_arbiter;

  logic m_clock = 1'b0;
  logic rst_n   = 1'b0;
  int   n_chk   = 0;
  int   n_err   = 0;

  always #5 m_clock = ~m_clock;

  rom_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  rom_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(4)) u_dut (
    .m_clock (m_clock),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  function automatic logic [31:0] rom_val(input int k);
    return 32'hC0DE_0000 | 32'(k);
  endfunction

  always @(posedge m_clock) bus.rom_q <= rom_val(int'(bus.rom_addr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da);
    @(negedge m_clock);
    bus.i_req  = ir;
    bus.i_addr = ia;
    bus.d_req  = dr;
    bus.d_addr = da;
    #1;
  endtask

  initial begin
    string pat;
    bus.i_req  = 1'b0;
    bus.i_addr = 32'h0;
    bus.d_req  = 1'b0;
    bus.d_addr = 32'h0;
    bus.rom_q  = 32'h0;

    // reset state
    #12;
    chk("rst_i_valid", 32'(bus.i_valid), 32'd0);
    chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
    chk("rst_i_err",   32'(bus.i_err),   32'd0);
    chk("rst_d_err",   32'(bus.d_err),   32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    @(negedge m_clock);
    rst_n = 1'b1;
    @(negedge m_clock);

    // I only at 0x10
    drive(1'b1, 32'h10, 1'b0, 32'h0);
    chk("ionly_i_ack", 32'(bus.i_ack), 32'd1);
    chk("ionly_d_ack", 32'(bus.d_ack), 32'd0);
    chk("ionly_rom_addr", 32'(bus.rom_addr), 32'd4);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chk("ionly_i_valid", 32'(bus.i_valid), 32'd1);
    chk("ionly_i_rdata", bus.i_rdata, rom_val(4));
    chk("ionly_d_valid", 32'(bus.d_valid), 32'd0);
    chk("ionly_d_rdata", bus.d_rdata, 32'd0);

    // both held: D four times, then I forced
    pat = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h40, 1'b1, 32'h20);
      chk($sformatf("both_d_ack_%0d", k), 32'(bus.d_ack), (pat[k] == "D") ? 32'd1 : 32'd0);
      chk($sformatf("both_i_ack_%0d", k), 32'(bus.i_ack), (pat[k] == "I") ? 32'd1 : 32'd0);
      chk($sformatf("both_rom_addr_%0d", k), 32'(bus.rom_addr), (pat[k] == "I") ? 32'd16 : 32'd8);
      if (k > 0) begin
        if (pat[k-1] == "D") begin
          chk($sformatf("both_d_valid_%0d", k), 32'(bus.d_valid), 32'd1);
          chk($sformatf("both_d_rdata_%0d", k), bus.d_rdata, rom_val(8));
          chk($sformatf("both_i_valid_%0d", k), 32'(bus.i_valid), 32'd0);
        end else begin
          chk($sformatf("both_i_valid_%0d", k), 32'(bus.i_valid), 32'd1);
          chk($sformatf("both_i_rdata_%0d", k), bus.i_rdata, rom_val(16));
          chk($sformatf("both_d_valid_%0d", k), 32'(bus.d_valid), 32'd0);
        end
      end
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chk("both_last_i_valid", 32'(bus.i_valid), 32'd1);
    chk("both_last_i_rdata", bus.i_rdata, rom_val(16));
    chk("both_last_d_valid", 32'(bus.d_valid), 32'd0);

    // back-to-back D stream 0x0, 0x4, 0x8
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(1'b0, 32'h0, 1'b1, 32'(k * 4));
      else       drive(1'b0, 32'h0, 1'b0, 32'h0);
      if (k < 3) begin
        chk($sformatf("strm_d_ack_%0d", k), 32'(bus.d_ack), 32'd1);
        chk($sformatf("strm_rom_addr_%0d", k), 32'(bus.rom_addr), 32'(k));
      end
      if (k > 0) begin
        chk($sformatf("strm_d_valid_%0d", k), 32'(bus.d_valid), 32'd1);
        chk($sformatf("strm_d_rdata_%0d", k), bus.d_rdata, rom_val(k - 1));
      end
    end

    // idle after a grant at 0x3C: rom_addr holds 15
    drive(1'b0, 32'h0, 1'b1, 32'h3C);
    chk("idle_rom_addr_gnt", 32'(bus.rom_addr), 32'd15);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chk("idle_d_valid_resp", 32'(bus.d_valid), 32'd1);
    chk("idle_d_rdata_resp", bus.d_rdata, rom_val(15));
    chk("idle_rom_addr_0", 32'(bus.rom_addr), 32'd15);
    for (int k = 1; k < 3; k++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      chk($sformatf("idle_rom_addr_%0d", k), 32'(bus.rom_addr), 32'd15);
      chk($sformatf("idle_d_valid_%0d", k), 32'(bus.d_valid), 32'd0);
      chk($sformatf("idle_i_valid_%0d", k), 32'(bus.i_valid), 32'd0);
    end

    // reset in the cycle after a D grant drops the response
    drive(1'b0, 32'h0, 1'b1, 32'h8);
    chk("rstmid_d_ack", 32'(bus.d_ack), 32'd1);
    @(negedge m_clock);
    bus.d_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_d_valid_in_rst", 32'(bus.d_valid), 32'd0);
    chk("rstmid_rom_addr", 32'(bus.rom_addr), 32'd0);
    @(negedge m_clock);
    rst_n = 1'b1;
    #1;
    chk("rstmid_d_valid_rel", 32'(bus.d_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chk("rstmid_d_valid_post", 32'(bus.d_valid), 32'd0);
    chk("rstmid_i_valid_post", 32'(bus.i_valid), 32'd0);
    drive(1'b1, 32'h14, 1'b0, 32'h0);
    chk("rstmid_i_ack", 32'(bus.i_ack), 32'd1);
    chk("rstmid_i_rom_addr", 32'(bus.rom_addr), 32'd5);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chk("rstmid_i_valid", 32'(bus.i_valid), 32'd1);
    chk("rstmid_i_rdata", bus.i_rdata, rom_val(5));

    // address above the ROM range
    drive(1'b0, 32'h0, 1'b1, 32'h1000);
    chk("oor_d_ack", 32'(bus.d_ack), 32'd1);
`ifdef ROM_ARB_RANGE_CHK_EN
    chk("oor_rom_addr", 32'(bus.rom_addr), 32'd5);
`else
    chk("oor_rom_addr", 32'(bus.rom_addr), 32'd0);
`endif
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chk("oor_d_valid", 32'(bus.d_valid), 32'd1);
`ifdef ROM_ARB_RANGE_CHK_EN
    chk("oor_d_err", 32'(bus.d_err), 32'd1);
    chk("oor_d_rdata", bus.d_rdata, 32'd0);
    chk("oor_rom_addr_hold", 32'(bus.rom_addr), 32'd5);
`else
    chk("oor_d_err", 32'(bus.d_err), 32'd0);
    chk("oor_d_rdata", bus.d_rdata, rom_val(0));
`endif
    chk("oor_i_err", 32'(bus.i_err), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    chk("oor_d_err_clear", 32'(bus.d_err), 32'd0);
    chk("oor_d_valid_clear", 32'(bus.d_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single synchronous code ROM (CodeROM instance inside rom_wrap: 10-bit word address, 32-bit q, 1-cycle read latency) between two requesters: instruction fetch (I) and data load (D).
- Arbitrates one access per cycle and routes the ROM output back to the requester that owns it.
- Priority is D-first, with a starvation bound that guarantees I forward progress.
- Sits between the core's fetch/load units and rom_wrap.

Parameters:
- ADDR_W, 10, ROM word-address width; rom_addr = addr[ADDR_W+1:2].
- DATA_W, 32, ROM data width.
- STARVE_LIMIT, 4, maximum consecutive D grants while I is pending before I is forced; legal range 1..15.

Ports:
- m_clock  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request, held until acknowledged.
- i_addr  in  32  fetch byte address.
- i_ack  out  1  fetch request accepted this cycle (combinational).
- i_valid  out  1  fetch data valid.
- i_rdata  out  DATA_W  fetch data.
- i_err  out  1  fetch address out of range (see Optional Feature).
- d_req  in  1  data-load request, held until acknowledged.
- d_addr  in  32  load byte address.
- d_ack  out  1  load accepted this cycle.
- d_valid  out  1  load data valid.
- d_rdata  out  DATA_W  load data.
- d_err  out  1  load address out of range.
- rom_addr  out  ADDR_W  address to ROM.
- rom_q  in  DATA_W  ROM read data.

Behaviour:
- Reset: the asynchronous assert of rst_n clears all of the following.
  - i_valid, d_valid, i_err, d_err = 0.
  - Owner register = NONE; streak counter = 0; rom_addr register = 0.
  - Any in-flight response is dropped; no valid is issued after reset release for a pre-reset grant.
- Grant decision (combinational, cycle N):
  - Only D requests: grant D.
  - Only I requests: grant I.
  - Both request and streak < STARVE_LIMIT: grant D and increment streak.
  - Both request and streak == STARVE_LIMIT: grant I and clear streak.
  - Streak clears on any cycle where I is granted or I is not requesting.
  - Streak saturates at STARVE_LIMIT.
- Accept timing: the granted requester sees its ack = 1 in cycle N. At most one ack per cycle. The requester may change its address or drop req from N+1.
- ROM address:
  - Grant cycle: rom_addr = granted addr[ADDR_W+1:2], driven combinationally.
  - No grant: rom_addr holds the last granted address from the register, so the ROM sees no spurious toggles.
  - addr[1:0] is ignored (word access only).
- Response, cycle N+1:
  - Owner register captures the grantee at the end of cycle N.
  - x_valid = 1 for exactly one cycle for the owner; x_rdata = rom_q.
  - Non-owner rdata = 0.
  - Back-to-back grants give one response per cycle with no bubble.
- Owner FSM: states NONE, OWN_I, OWN_D. Next state = grantee, or NONE if no grant. No other states.
- Simultaneous events: a new grant in cycle N+1 while the response for N is presented is legal (pipelined).
- Latency: 1 cycle from ack to valid. Throughput: 1 access per cycle.

Optional Feature:
- Macro ROM_ARB_RANGE_CHK_EN.
- Defined:
  - A request with addr[31:ADDR_W+2] != 0 is still acked in arbitration order, but rom_addr is not updated.
  - In N+1: x_valid = 1, x_err = 1, x_rdata = 0.
- Undefined:
  - Upper address bits are ignored (aliasing); i_err and d_err are tied to 0.
  - No comparator logic is generated.

Decomposition:
- Package rom_arb_pkg holds:
  - owner encoding OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2;
  - default ROM_ADDR_W = 10, ROM_DATA_W = 32;
  - STARVE_LIMIT_MAX = 15.
- One sub-module, rom_arb_starve_cnt: 4-bit saturating counter with inc/clr inputs, a limit-reached output, and async reset. The grant logic, owner FSM and response muxing stay in rom_arbiter.

Test Plan:
- Reset then I-only: i_req = 1, i_addr = 0x10 → i_ack = 1 in cycle 0, rom_addr = 4; cycle 1 i_valid = 1, i_rdata = ROM[4]; d_valid stays 0.
- Both held, STARVE_LIMIT = 4, d_addr = 0x20, i_addr = 0x40:
  - grants are D,D,D,D,I,D,D,D,D,I...;
  - responses arrive one cycle later with d_rdata = ROM[8] and i_rdata = ROM[16].
- Back-to-back D streaming, addresses 0x0,0x4,0x8 → d_valid high for 3 consecutive cycles with ROM[0],ROM[1],ROM[2]; no bubbles.
- Idle after grant at 0x3C → rom_addr holds 15 on idle cycles; no valid is asserted.
- rst_n low in the cycle after a D grant → d_valid stays 0 after release, owner = NONE, and the next I request is served normally.
- ROM_ARB_RANGE_CHK_EN defined, d_addr = 0x1000 → d_ack = 1; next cycle d_valid = 1, d_err = 1, d_rdata = 0; rom_addr unchanged. With the macro undefined, the same stimulus returns ROM[0] with d_err = 0.
